// File: rtl/ssram_arbiter.sv
// Two-requester round-robin arbiter and strobe sequencer for a 32-bit SSRAM.
// Ports: clk/rst, req_* (two requesters), rsp_* (completion), ssram_* (pad side).
module ssram_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [31:0]       req_wdata0,
  input  logic [31:0]       req_wdata1,
  input  logic [3:0]        req_be0,
  input  logic [3:0]        req_be1,
  output logic [1:0]        rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] ssram_addr,
  output logic              ssram_adsc_n,
  output logic              ssram_cs_n,
  output logic              ssram_oe_n,
  output logic              ssram_we_n,
  output logic [3:0]        ssram_be_n,
  output logic [31:0]       ssram_dq_out,
  output logic              ssram_dq_oe,
  input  logic [31:0]       ssram_dq_in
);

  typedef enum logic [2:0] {
    IDLE, ADDR, RD_WAIT, RD_RSP, WR_TURN
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  state_e              state_q;
  logic                ptr_q;
  logic                owner_q;
  logic                we_q;
  logic [2:0]          cnt_q;
  logic [1:0]          rsp_valid_q;
  logic [31:0]         rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                adsc_n_q, cs_n_q, oe_n_q, we_n_q;
  logic [3:0]          be_n_q;
  logic [31:0]         dq_out_q;
  logic                dq_oe_q;

  logic                gnt0, gnt1, hs;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic [3:0]          sel_be;

  // ptr_q names the requester that wins a tie.
  assign gnt0 = req_valid[0] & (~req_valid[1] | ~ptr_q);
  assign gnt1 = req_valid[1] & (~req_valid[0] |  ptr_q);

  assign req_ready = (state_q == IDLE) ? {gnt1, gnt0} : 2'b00;
  assign hs        = |req_ready;

  assign sel_we    = gnt1 ? req_we[1]  : req_we[0];
  assign sel_addr  = gnt1 ? req_addr1  : req_addr0;
  assign sel_wdata = gnt1 ? req_wdata1 : req_wdata0;
  assign sel_be    = gnt1 ? req_be1    : req_be0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      addr_q      <= '0;
      adsc_n_q    <= 1'b1;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            owner_q  <= gnt1;
            we_q     <= sel_we;
            ptr_q    <= ~gnt1;
            addr_q   <= sel_addr;
            be_n_q   <= ~sel_be;
            adsc_n_q <= 1'b0;
            cs_n_q   <= 1'b0;
            if (sel_we) begin
              we_n_q   <= 1'b0;
              dq_oe_q  <= 1'b1;
              dq_out_q <= sel_wdata;
            end else begin
              oe_n_q   <= 1'b0;
            end
            state_q  <= ADDR;
          end
        end
        ADDR: begin
          adsc_n_q <= 1'b1;
          cs_n_q   <= 1'b1;
          we_n_q   <= 1'b1;
          be_n_q   <= 4'hF;
          dq_oe_q  <= 1'b0;
          if (we_q) begin
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= WR_TURN;
          end else begin
            cnt_q   <= LAT_M1;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 3'd0) begin
            rdata_q     <= ssram_dq_in;
            oe_n_q      <= 1'b1;
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= RD_RSP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RD_RSP:  state_q <= IDLE;
        WR_TURN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign ssram_addr   = addr_q;
  assign ssram_adsc_n = adsc_n_q;
  assign ssram_cs_n   = cs_n_q;
  assign ssram_oe_n   = oe_n_q;
  assign ssram_we_n   = we_n_q;
  assign ssram_be_n   = be_n_q;
  assign ssram_dq_out = dq_out_q;
  assign ssram_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_ssram_arbiter.sv
// Directed bench for ssram_arbiter with a small SSRAM behavioural model.
// Scenarios: reset, write, read, fairness, byte write, reset mid-read.
module tb_ssram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [19:0] req_addr0, req_addr1, ssram_addr;
  logic [31:0] req_wdata0, req_wdata1, rsp_rdata;
  logic [3:0]  req_be0, req_be1, ssram_be_n;
  logic        ssram_adsc_n, ssram_cs_n, ssram_oe_n, ssram_we_n;
  logic [31:0] ssram_dq_out, ssram_dq_in;
  logic        ssram_dq_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ssram_arbiter #(.ADDR_W(20), .READ_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_be0(req_be0), .req_be1(req_be1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ssram_addr(ssram_addr), .ssram_adsc_n(ssram_adsc_n),
    .ssram_cs_n(ssram_cs_n), .ssram_oe_n(ssram_oe_n),
    .ssram_we_n(ssram_we_n), .ssram_be_n(ssram_be_n),
    .ssram_dq_out(ssram_dq_out), .ssram_dq_oe(ssram_dq_oe),
    .ssram_dq_in(ssram_dq_in)
  );

  // SSRAM model: writes on the ADSC edge, reads return the word
  // addressed on the ADSC edge until the next read cycle.
  logic [31:0] mem [256];
  logic [7:0]  rd_addr = 8'd0;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    if (!ssram_adsc_n && !ssram_cs_n) begin
      if (!ssram_we_n) begin
        for (int b = 0; b < 4; b++)
          if (!ssram_be_n[b]) mem[ssram_addr[7:0]][8*b +: 8] <= ssram_dq_out[8*b +: 8];
      end else begin
        rd_addr <= ssram_addr[7:0];
      end
    end
  end

  assign ssram_dq_in = mem[rd_addr];

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    total++; if ({ssram_adsc_n, ssram_cs_n, ssram_oe_n, ssram_we_n} !== 4'hF) begin bad++; $display("FAIL reset_strobes got=%h want=f", {ssram_adsc_n, ssram_cs_n, ssram_oe_n, ssram_we_n}); end
    total++; if (ssram_be_n !== 4'hF) begin bad++; $display("FAIL reset_be_n got=%h want=f", ssram_be_n); end
    total++; if (ssram_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_dq_oe got=%b want=0", ssram_dq_oe); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
    total++; if (ssram_addr !== 20'h0 || ssram_dq_out !== 32'h0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h/%h want=0", ssram_addr, ssram_dq_out, rsp_rdata); end
    tick();
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", req_ready); end
  endtask

  task automatic test_write;
    req_valid = 2'b01; req_we = 2'b01;
    req_addr0 = 20'h00010; req_wdata0 = 32'hDEADBEEF; req_be0 = 4'hF;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready got=%b want=01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    total++; if ({ssram_adsc_n, ssram_cs_n, ssram_we_n, ssram_oe_n} !== 4'b0001) begin bad++; $display("FAIL wr_addr_strobes got=%b want=0001", {ssram_adsc_n, ssram_cs_n, ssram_we_n, ssram_oe_n}); end
    total++; if (ssram_dq_out !== 32'hDEADBEEF || ssram_dq_oe !== 1'b1) begin bad++; $display("FAIL wr_dq got=%h oe=%b want=deadbeef oe=1", ssram_dq_out, ssram_dq_oe); end
    total++; if (ssram_addr !== 20'h00010 || ssram_be_n !== 4'h0) begin bad++; $display("FAIL wr_addr got=%h be_n=%h want=00010 be_n=0", ssram_addr, ssram_be_n); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_rsp_early got=%b want=00", rsp_valid); end
    tick();
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL wr_rsp got=%b want=01", rsp_valid); end
    total++; if ({ssram_adsc_n, ssram_cs_n, ssram_we_n, ssram_dq_oe} !== 4'b1110) begin bad++; $display("FAIL wr_turn got=%b want=1110", {ssram_adsc_n, ssram_cs_n, ssram_we_n, ssram_dq_oe}); end
    tick();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_rsp_len got=%b want=00", rsp_valid); end
  endtask

  task automatic test_read;
    logic [1:0] ev;
    logic       eo, ea;
    req_valid = 2'b10; req_we = 2'b00; req_addr1 = 20'h00010;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rd_ready got=%b want=10", req_ready); end
    tick();
    req_valid = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      #1;
      ev = (k == 4) ? 2'b10 : 2'b00;
      eo = (k <= 3) ? 1'b0 : 1'b1;
      ea = (k == 1) ? 1'b0 : 1'b1;
      total++; if (rsp_valid !== ev) begin bad++; $display("FAIL rd_rsp k=%0d got=%b want=%b", k, rsp_valid, ev); end
      total++; if (ssram_oe_n !== eo) begin bad++; $display("FAIL rd_oe_n k=%0d got=%b want=%b", k, ssram_oe_n, eo); end
      total++; if (ssram_adsc_n !== ea || ssram_dq_oe !== 1'b0) begin bad++; $display("FAIL rd_adsc k=%0d got=%b oe=%b want=%b oe=0", k, ssram_adsc_n, ssram_dq_oe, ea); end
      if (k == 4) begin
        total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", rsp_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_fair;
    int n, cyc;
    int ids [4];
    int ts  [4];
    n = 0; cyc = 0;
    req_valid = 2'b11; req_we = 2'b00;
    req_addr0 = 20'h00020; req_addr1 = 20'h00030;
    while (n < 4 && cyc < 60) begin
      #1;
      if (req_ready != 2'b00) begin
        ids[n] = req_ready[1] ? 1 : 0;
        ts[n]  = cyc;
        n++;
      end
      tick();
      cyc++;
    end
    req_valid = 2'b00;
    total++; if (n !== 4) begin bad++; $display("FAIL fair_count got=%0d want=4", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (ids[i] !== (i % 2)) begin bad++; $display("FAIL fair_order i=%0d got=%0d want=%0d", i, ids[i], i % 2); end
      if (i > 0) begin
        total++; if (ts[i] - ts[i-1] !== 5) begin bad++; $display("FAIL fair_gap i=%0d got=%0d want=5", i, ts[i] - ts[i-1]); end
      end
    end
    repeat (6) tick();
  endtask

  task automatic test_byte_write;
    req_valid = 2'b10; req_we = 2'b10;
    req_addr1 = 20'h00040; req_wdata1 = 32'h11223344; req_be1 = 4'b0010;
    #1;
    total++; if (ssram_be_n !== 4'hF) begin bad++; $display("FAIL bw_be_pre got=%h want=f", ssram_be_n); end
    tick();
    req_valid = 2'b00;
    #1;
    total++; if (ssram_be_n !== 4'b1101 || ssram_we_n !== 1'b0) begin bad++; $display("FAIL bw_be_addr got=%b we_n=%b want=1101 we_n=0", ssram_be_n, ssram_we_n); end
    tick();
    #1;
    total++; if (ssram_be_n !== 4'hF || rsp_valid !== 2'b10) begin bad++; $display("FAIL bw_be_turn got=%h rsp=%b want=f rsp=10", ssram_be_n, rsp_valid); end
    tick();
    total++; if (ssram_be_n !== 4'hF) begin bad++; $display("FAIL bw_be_post got=%h want=f", ssram_be_n); end
    total++; if (mem[8'h40] !== 32'h00003300) begin bad++; $display("FAIL bw_mem got=%h want=00003300", mem[8'h40]); end
  endtask

  task automatic test_reset_mid;
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 20'h00010;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    total++; if (ssram_oe_n !== 1'b0 || ssram_adsc_n !== 1'b1) begin bad++; $display("FAIL rm_wait got=oe%b adsc%b want=oe0 adsc1", ssram_oe_n, ssram_adsc_n); end
    rst = 1'b1;
    tick();
    total++; if ({ssram_adsc_n, ssram_cs_n, ssram_oe_n, ssram_we_n} !== 4'hF || ssram_dq_oe !== 1'b0) begin bad++; $display("FAIL rm_strobes got=%h dq_oe=%b want=f dq_oe=0", {ssram_adsc_n, ssram_cs_n, ssram_oe_n, ssram_we_n}, ssram_dq_oe); end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rm_no_rsp k=%0d got=%b want=00", k, rsp_valid); end
      tick();
    end
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rm_ptr got=%b want=01", req_ready); end
    tick();
    req_valid = 2'b00;
    repeat (6) tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    req_be0 = 4'hF; req_be1 = 4'hF;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_fair();
    test_byte_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
